// File: rtl/wt_cache_pkg.sv
// Shared types for the write-through cache subsystem.
// Holds the invalidation queue state encoding and its default line address type.
package wt_cache_pkg;

    localparam int unsigned INVQ_ADDR_W      = 64;
    localparam int unsigned INVQ_LINE_OFFSET = 4;

    typedef enum logic {
        INVQ_RUN,
        INVQ_FLUSH
    } invq_state_e;

    typedef logic [INVQ_ADDR_W-INVQ_LINE_OFFSET-1:0] invq_line_t;

endpackage

// File: rtl/wt_inval_queue.sv
// Coherence invalidation queue in front of the write-through cache invalidation port.
// Drops queued duplicates; on overflow it discards all entries and requests a full D$ flush.
module wt_inval_queue
    import wt_cache_pkg::*;
#(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned ADDR_W      = INVQ_ADDR_W,
    parameter int unsigned LINE_OFFSET = INVQ_LINE_OFFSET
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     snoop_valid_i,
    input  logic [ADDR_W-1:0]        snoop_addr_i,
    output logic                     snoop_ready_o,
    output logic                     inval_valid_o,
    output logic [ADDR_W-1:0]        inval_addr_o,
    input  logic                     inval_ready_i,
    output logic                     flush_req_o,
    input  logic                     flush_ack_i,
    output logic [$clog2(DEPTH):0]   occupancy_o,
    output logic                     dup_drop_o,
    output logic                     overflow_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned LA_W  = ADDR_W - LINE_OFFSET;

    typedef logic [LA_W-1:0] line_t;

    invq_state_e        state_q, state_d;
    line_t              lines_q [DEPTH];
    logic [DEPTH-1:0]   valid_q;
    logic [PTR_W-1:0]   head_q, tail_q;
    logic [CNT_W-1:0]   count_q;
    logic               dup_drop_q, overflow_q;

    line_t              snoop_line;
    logic [DEPTH-1:0]   match;
    logic               pop, accept, dup_hit, has_room, push, ovf;
    logic               unused_offset;

    assign snoop_line    = snoop_addr_i[ADDR_W-1:LINE_OFFSET];
    assign unused_offset = ^snoop_addr_i[LINE_OFFSET-1:0];

    assign inval_valid_o = (state_q == INVQ_RUN) && (count_q != '0);
    assign inval_addr_o  = {lines_q[head_q], {LINE_OFFSET{1'b0}}};
    assign occupancy_o   = count_q;
    assign dup_drop_o    = dup_drop_q;
    assign overflow_o    = overflow_q;

    assign pop = inval_valid_o && inval_ready_i;

    // The entry leaving this cycle is excluded so a re-snoop of it is queued again.
    always_comb begin
        match = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            match[i] = valid_q[i] && (lines_q[i] == snoop_line)
                       && !(pop && (head_q == PTR_W'(i)));
        end
    end

    assign accept   = (state_q == INVQ_RUN) && snoop_valid_i;
    assign dup_hit  = accept && (|match);
    assign has_room = (count_q != CNT_W'(DEPTH)) || pop;
    assign push     = accept && !dup_hit && has_room;
    assign ovf      = accept && !dup_hit && !has_room;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= INVQ_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        snoop_ready_o = 1'b0;
        flush_req_o   = 1'b0;
        unique case (state_q)
            INVQ_RUN: begin
                snoop_ready_o = 1'b1;
                if (ovf) begin
                    state_d = INVQ_FLUSH;
                end
            end
            INVQ_FLUSH: begin
                flush_req_o = 1'b1;
                if (flush_ack_i) begin
                    state_d = INVQ_RUN;
                end
            end
            default: state_d = INVQ_RUN;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            valid_q    <= '0;
            dup_drop_q <= 1'b0;
            overflow_q <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                lines_q[i] <= '0;
            end
        end else begin
            dup_drop_q <= dup_hit;
            overflow_q <= ovf;
            if (ovf) begin
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
                valid_q <= '0;
            end else begin
                // Pop clears before push sets, so a full queue can recycle the head slot.
                if (pop) begin
                    valid_q[head_q] <= 1'b0;
                    head_q          <= head_q + PTR_W'(1);
                end
                if (push) begin
                    lines_q[tail_q] <= snoop_line;
                    valid_q[tail_q] <= 1'b1;
                    tail_q          <= tail_q + PTR_W'(1);
                end
                unique case ({push, pop})
                    2'b10:   count_q <= count_q + CNT_W'(1);
                    2'b01:   count_q <= count_q - CNT_W'(1);
                    default: count_q <= count_q;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_wt_inval_queue.sv
// Scoreboard bench for wt_inval_queue: random and directed snoop traffic against a
// queue-level reference model; a separate monitor compares every cycle.
module tb_wt_inval_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 64;
    localparam int unsigned LO    = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          snoop_valid = 1'b0;
    logic [AW-1:0] snoop_addr = '0;
    logic          snoop_ready;
    logic          inval_valid;
    logic [AW-1:0] inval_addr;
    logic          inval_ready = 1'b0;
    logic          flush_req;
    logic          flush_ack = 1'b0;
    logic [2:0]    occupancy;
    logic          dup_drop;
    logic          overflow;

    wt_inval_queue #(.DEPTH(DEPTH), .ADDR_W(AW), .LINE_OFFSET(LO)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .snoop_valid_i(snoop_valid),
        .snoop_addr_i (snoop_addr),
        .snoop_ready_o(snoop_ready),
        .inval_valid_o(inval_valid),
        .inval_addr_o (inval_addr),
        .inval_ready_i(inval_ready),
        .flush_req_o  (flush_req),
        .flush_ack_i  (flush_ack),
        .occupancy_o  (occupancy),
        .dup_drop_o   (dup_drop),
        .overflow_o   (overflow)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: queue of line addresses plus a flushing flag.
    logic [AW-LO-1:0] mq[$];
    logic [AW-LO-1:0] sbq[$];
    bit               mflush = 1'b0;
    bit               exp_dup = 1'b0;
    bit               exp_ovf = 1'b0;
    bit               mon_en = 1'b0;

    task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit v, input logic [AW-1:0] a, input bit r,
                              input bit ack, input bit rn);
        logic [AW-LO-1:0] la;
        bit dup;
        la = a[AW-1:LO];
        exp_dup = 1'b0;
        exp_ovf = 1'b0;
        if (!rn) begin
            mq.delete();
            sbq.delete();
            mflush = 1'b0;
        end else if (mflush) begin
            if (ack) mflush = 1'b0;
        end else begin
            if (r && mq.size() > 0) void'(mq.pop_front());
            dup = 1'b0;
            foreach (mq[i]) if (mq[i] == la) dup = 1'b1;
            if (v && dup) begin
                exp_dup = 1'b1;
            end else if (v) begin
                if (mq.size() < DEPTH) begin
                    mq.push_back(la);
                    sbq.push_back(la);
                end else begin
                    mq.delete();
                    sbq.delete();
                    mflush  = 1'b1;
                    exp_ovf = 1'b1;
                end
            end
        end
    endtask

    task automatic cycle(input bit v, input logic [AW-1:0] a, input bit r,
                         input bit ack, input bit rn);
        @(negedge clk);
        #1;
        snoop_valid = v;
        snoop_addr  = a;
        inval_ready = r;
        flush_ack   = ack;
        rst_n       = rn;
        #2;
        model_step(v, a, r, ack, rn);
    endtask

    // Called right after cycle(): moves to just past the following clock edge.
    task automatic after_edge();
        #4;
    endtask

    // Monitor: compares DUT outputs against the model and drains the scoreboard on handshakes.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                chk("snoop_ready", 64'(snoop_ready), 64'(!mflush));
                chk("flush_req",   64'(flush_req),   64'(mflush));
                chk("inval_valid", 64'(inval_valid), 64'(!mflush && mq.size() != 0));
                chk("occupancy",   64'(occupancy),   64'(mq.size()));
                chk("dup_drop",    64'(dup_drop),    64'(exp_dup));
                chk("overflow",    64'(overflow),    64'(exp_ovf));
                if (inval_valid) begin
                    if (sbq.size() == 0) begin
                        chk("inval_unexpected", 64'(inval_valid), 64'(0));
                    end else begin
                        chk("inval_addr", inval_addr, {sbq[0], 4'h0});
                        if (inval_ready) void'(sbq.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        // Reset
        cycle(0, '0, 0, 0, 0);
        cycle(0, '0, 0, 0, 0);
        mon_en = 1'b1;
        after_edge();
        chk("reset_addr", inval_addr, 64'h0);
        chk("reset_occ", 64'(occupancy), 64'h0);

        // Single request
        cycle(1, 64'h8000_1234, 0, 0, 1);
        after_edge();
        chk("single_valid", 64'(inval_valid), 64'h1);
        chk("single_addr", inval_addr, 64'h8000_1230);
        cycle(0, '0, 1, 0, 1);
        after_edge();
        chk("single_empty", 64'(inval_valid), 64'h0);

        // Duplicate
        cycle(1, 64'h100, 0, 0, 1);
        cycle(1, 64'h10C, 0, 0, 1);
        after_edge();
        chk("dup_pulse", 64'(dup_drop), 64'h1);
        chk("dup_occ", 64'(occupancy), 64'h1);
        cycle(0, '0, 1, 0, 1);
        after_edge();
        chk("dup_drained", 64'(occupancy), 64'h0);

        // Pop-match
        cycle(1, 64'h200, 0, 0, 1);
        cycle(1, 64'h208, 1, 0, 1);
        after_edge();
        chk("popmatch_nodup", 64'(dup_drop), 64'h0);
        chk("popmatch_addr", inval_addr, 64'h200);
        cycle(0, '0, 1, 0, 1);

        // Fill and overflow
        for (int i = 0; i < 4; i++) cycle(1, 64'(i * 16), 0, 0, 1);
        cycle(1, 64'h40, 0, 0, 1);
        after_edge();
        chk("ovf_pulse", 64'(overflow), 64'h1);
        chk("ovf_occ", 64'(occupancy), 64'h0);
        chk("ovf_flush", 64'(flush_req), 64'h1);
        chk("ovf_ready", 64'(snoop_ready), 64'h0);
        cycle(0, '0, 0, 1, 1);
        after_edge();
        chk("ack_run", 64'(snoop_ready), 64'h1);

        // Full plus pop
        for (int i = 0; i < 4; i++) cycle(1, 64'(i * 16), 0, 0, 1);
        cycle(1, 64'h50, 1, 0, 1);
        after_edge();
        chk("fullpop_noovf", 64'(overflow), 64'h0);
        chk("fullpop_occ", 64'(occupancy), 64'h4);
        chk("fullpop_head", inval_addr, 64'h10);
        for (int i = 0; i < 4; i++) cycle(0, '0, 1, 0, 1);

        // Reset during flush
        for (int i = 0; i < 5; i++) cycle(1, 64'(i * 16), 0, 0, 1);
        cycle(0, '0, 0, 0, 0);
        after_edge();
        chk("rstflush_req", 64'(flush_req), 64'h0);
        chk("rstflush_occ", 64'(occupancy), 64'h0);
        cycle(0, '0, 0, 1, 1);
        after_edge();
        chk("spurious_ack", 64'(snoop_ready), 64'h1);

        // Random traffic over a small address pool to provoke duplicates and overflows
        for (int n = 0; n < 3000; n++) begin
            logic [AW-1:0] a;
            a = {32'h0000_0000, 24'h0, 4'($urandom_range(0, 7)), 4'($urandom_range(0, 15))};
            if ($urandom_range(0, 3) == 0) a[40] = 1'b1;
            cycle($urandom_range(0, 9) < 6, a, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 9) < 3, $urandom_range(0, 99) != 0);
        end

        cycle(0, '0, 1, 0, 1);
        @(negedge clk);
        #3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
